// File: rtl/seven_display_mux_pkg.sv
// Segment encoding constants shared by the seven-segment scan driver and its decoder.
package seg_pkg;
  localparam int SEG_W  = 8;
  localparam int DP_BIT = 0;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Index 0 is the rightmost entry; bits are {a,b,c,d,e,f,g,dp}
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    8'h8E, 8'hDE, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE4, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction
endpackage

// File: rtl/seven_display_mux_if.sv
// Value/control inputs and segment/strobe outputs of the seven-segment scan driver.
interface seven_display_mux_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic [SEG_W-1:0]        display;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_tick;
  logic                    update_pending;

  modport master (
    output enable, load, value, dp_mask, blank_lz,
    input  display, digit_sel, frame_tick, update_pending
  );

  modport slave (
    input  enable, load, value, dp_mask, blank_lz,
    output display, digit_sel, frame_tick, update_pending
  );
endinterface

// File: rtl/seven_display_mux_decode.sv
// Nibble to segment pattern, with blanking and a decimal point that survives blanking.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       i_nibble,
  input  logic             i_dp,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);
  assign o_seg = (i_blank ? SEG_BLANK : hex_to_seg(i_nibble)) | (SEG_W'(i_dp) << DP_BIT);
endmodule

// File: rtl/seven_display_mux.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS nibbles, blanks leading zeros,
// and swaps in newly loaded values only at frame boundaries so a frame never tears.
module seven_display_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_display_mux_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic ACT_LOW = (DIGIT_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{ACT_LOW}};

  logic [PS_W-1:0]         r_prescale;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow_value;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_upd_pending;
  logic [SEG_W-1:0]        r_display;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic                    r_frame_tick;

  logic                    w_last_ps;
  logic                    w_last_idx;
  logic                    w_boundary;
  logic                    w_commit;
  logic [3:0]              w_nibs [NUM_DIGITS];
  logic [NUM_DIGITS:0]     w_hi_zero;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [SEG_W-1:0]        w_seg;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_sel_active;

  assign w_last_ps  = (r_prescale == PS_W'(REFRESH_DIV - 1));
  assign w_last_idx = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_boundary = bus.enable && w_last_ps && w_last_idx;
  // While dark there is no frame to tear, so pending data may land at once
  assign w_commit   = w_boundary || !bus.enable;

  // Zero-run from the most significant digit down; digit 0 always stays visible
  assign w_hi_zero[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibs[gi]    = r_shadow_value[4*gi +: 4];
      assign w_hi_zero[gi] = (w_nibs[gi] == 4'h0) && w_hi_zero[gi+1];
      assign w_lz_mask[gi] = (gi != 0) && w_hi_zero[gi];
    end
  endgenerate

  seg_hex_decode u_decode (
    .i_nibble (w_nibs[r_idx]),
    .i_dp     (r_shadow_dp[r_idx]),
    .i_blank  (bus.blank_lz && w_lz_mask[r_idx]),
    .o_seg    (w_seg)
  );

  assign w_onehot     = NUM_DIGITS'(1) << r_idx;
  assign w_sel_active = ACT_LOW ? ~w_onehot : w_onehot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescale     <= '0;
      r_idx          <= '0;
      r_pend_value   <= '0;
      r_pend_dp      <= '0;
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
      r_upd_pending  <= 1'b0;
      r_display      <= SEG_BLANK;
      r_digit_sel    <= SEL_IDLE;
      r_frame_tick   <= 1'b0;
    end else begin
      if (!bus.enable) begin
        r_prescale <= '0;
        r_idx      <= '0;
      end else if (w_last_ps) begin
        r_prescale <= '0;
        r_idx      <= w_last_idx ? '0 : r_idx + 1'b1;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end

      if (bus.load) begin
        r_pend_value <= bus.value;
        r_pend_dp    <= bus.dp_mask;
        if (w_commit) begin
          r_shadow_value <= bus.value;
          r_shadow_dp    <= bus.dp_mask;
          r_upd_pending  <= 1'b0;
        end else begin
          r_upd_pending  <= 1'b1;
        end
      end else if (w_commit) begin
        r_shadow_value <= r_pend_value;
        r_shadow_dp    <= r_pend_dp;
        r_upd_pending  <= 1'b0;
      end

      r_frame_tick <= w_boundary;
      r_display    <= bus.enable ? w_seg : SEG_BLANK;
      r_digit_sel  <= bus.enable ? w_sel_active : SEL_IDLE;
    end
  end

  assign bus.display        = r_display;
  assign bus.digit_sel      = r_digit_sel;
  assign bus.frame_tick     = r_frame_tick;
  assign bus.update_pending = r_upd_pending;
endmodule

// File: tb/tb_seven_display_mux.sv
// Randomized and directed checks of seven_display_mux against a frame-position reference model.
module tb_seven_display_mux;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;
  localparam logic [7:0] GLYPHS [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE4,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'hDE, 8'h8E
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_display_mux_if #(.NUM_DIGITS(N)) u_if ();

  seven_display_mux #(
    .NUM_DIGITS       (N),
    .REFRESH_DIV      (DIV),
    .DIGIT_ACTIVE_LOW (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: scan position is simply cycles elapsed since scanning (re)started
  int          m_cnt = 0;
  logic [15:0] m_shadow_v = '0, m_pend_v = '0;
  logic [3:0]  m_shadow_dp = '0, m_pend_dp = '0;
  logic        m_upd = 1'b0;
  logic [7:0]  exp_display = '0;
  logic [3:0]  exp_sel = 4'hF;
  logic        exp_tick = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input logic blz, input int d);
    logic [15:0] upper;
    logic        blank;
    upper = v >> (4 * d);
    blank = blz && (d > 0) && (upper == 16'h0);
    return (blank ? 8'h00 : GLYPHS[upper[3:0]]) | {7'b0, dp[d]};
  endfunction

  task automatic model_edge();
    int   digit;
    logic boundary;
    logic commit;
    if (!rst_n) begin
      m_cnt = 0; m_shadow_v = '0; m_pend_v = '0; m_shadow_dp = '0; m_pend_dp = '0;
      m_upd = 1'b0; exp_display = 8'h00; exp_sel = 4'hF; exp_tick = 1'b0;
    end else begin
      digit       = (m_cnt / DIV) % N;
      boundary    = u_if.enable && ((m_cnt % FRAME) == FRAME - 1);
      commit      = boundary || !u_if.enable;
      exp_display = u_if.enable ? ref_seg(m_shadow_v, m_shadow_dp, u_if.blank_lz, digit) : 8'h00;
      exp_sel     = u_if.enable ? ~(4'b0001 << digit) : 4'hF;
      exp_tick    = boundary;
      if (u_if.load) begin
        m_pend_v  = u_if.value;
        m_pend_dp = u_if.dp_mask;
        if (commit) begin
          m_shadow_v = u_if.value; m_shadow_dp = u_if.dp_mask; m_upd = 1'b0;
        end else begin
          m_upd = 1'b1;
        end
      end else if (commit) begin
        m_shadow_v = m_pend_v; m_shadow_dp = m_pend_dp; m_upd = 1'b0;
      end
      m_cnt = u_if.enable ? m_cnt + 1 : 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("display", u_if.display, exp_display);
    check_eq("digit_sel", u_if.digit_sel, exp_sel);
    check_eq("frame_tick", u_if.frame_tick, exp_tick);
    check_eq("update_pending", u_if.update_pending, m_upd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_pos(input int pos);
    int k;
    k = 0;
    while ((m_cnt % FRAME) != pos && k < 64) begin
      cycle();
      k++;
    end
    check_eq("wait_pos", m_cnt % FRAME, pos);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    u_if.value   = v;
    u_if.dp_mask = dp;
    u_if.load    = 1'b1;
    $display("[TB] load value=%h dp=%b pos=%0d", v, dp, m_cnt % FRAME);
    cycle();
    u_if.load = 1'b0;
  endtask

  initial begin
    logic [15:0] rv;
    u_if.enable = 1'b0; u_if.load = 1'b0; u_if.value = '0;
    u_if.dp_mask = '0; u_if.blank_lz = 1'b0;
    rst_n = 1'b0;

    run(3);
    check_eq("rst_display", u_if.display, 8'h00);
    check_eq("rst_sel", u_if.digit_sel, 4'hF);

    rst_n = 1'b1;
    u_if.enable = 1'b1;
    cycle();
    check_eq("first_display", u_if.display, 8'hFC);
    check_eq("first_sel", u_if.digit_sel, 4'b1110);

    wait_pos(2);
    do_load(16'h12AF, 4'b0000);
    run(40);

    u_if.blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(36);
    do_load(16'h0000, 4'b0000);
    run(36);
    do_load(16'h0050, 4'b0100);
    run(36);
    wait_pos(9);
    check_eq("lz_dp_display", u_if.display, 8'h01);
    check_eq("lz_dp_sel", u_if.digit_sel, 4'b1011);
    u_if.blank_lz = 1'b0;

    wait_pos(5);
    do_load(16'h3333, 4'b0000);
    check_eq("mid_upd", u_if.update_pending, 1'b1);
    run(40);

    wait_pos(15);
    do_load(16'h4567, 4'b0001);
    check_eq("bnd_upd", u_if.update_pending, 1'b0);
    run(20);

    wait_pos(9);
    u_if.enable = 1'b0;
    cycle();
    check_eq("dark_display", u_if.display, 8'h00);
    check_eq("dark_sel", u_if.digit_sel, 4'hF);
    run(3);
    u_if.enable = 1'b1;
    run(20);

    wait_pos(3);
    do_load(16'hBEEF, 4'b1010);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(40);

    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 499) != 0);
      u_if.enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 99) == 0) u_if.blank_lz = ~u_if.blank_lz;
      u_if.load = ($urandom_range(0, 15) == 0);
      if (u_if.load) begin
        for (int d = 0; d < N; d++)
          rv[4*d +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        u_if.value   = rv;
        u_if.dp_mask = 4'($urandom);
        $display("[TB] load value=%h dp=%b pos=%0d", u_if.value, u_if.dp_mask, m_cnt % FRAME);
      end
      cycle();
    end
    rst_n = 1'b1; u_if.enable = 1'b1; u_if.load = 1'b0;
    run(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
